// File: rtl/axi4lite_imem_rd_arbiter_pkg.sv
// Shared AXI4-Lite constants and types for the instruction-ROM read arbiter.
package axi4lite_imem_rd_arbiter_pkg;
  typedef logic [1:0] axi_resp_t;
  typedef logic [2:0] axi_prot_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_prot_t ARPROT_INSN = 3'b100;
endpackage

// File: rtl/axi4lite_imem_rd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  int idx_s;

  // scan from the pointer, first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < N; i++) begin
      idx_s = (int'(ptr) + i) % N;
      if (!any && req[idx_s]) begin
        any          = 1'b1;
        gnt[idx_s]   = 1'b1;
        gnt_idx      = IW'(idx_s);
      end else begin
        any = any;
      end
    end
  end
endmodule

// File: rtl/axi4lite_imem_rd_arbiter.sv
// Round-robin arbiter sharing the IMEM AXI4-Lite read port; one outstanding read,
// out-of-range addresses answered locally with SLVERR.
module axi4lite_imem_rd_arbiter
  import axi4lite_imem_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int IMEM_BYTES = 1048576,
  parameter int R_SETTLE   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  output logic [NUM_REQ-1:0]            req_arready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [1:0]                    req_rresp,
  output logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [2:0]                    m_arprot,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT  = (ADDR_WIDTH+1)'(IMEM_BYTES);
  localparam logic [2:0]          SETTLE_LAST = 3'(R_SETTLE);

  logic [2:0]            state_r, state_nx_s;
  logic [2:0]            cnt_r, cnt_nx_s;
  logic [IW-1:0]         ptr_r, gid_r, gidx_s, gid_next_s;
  logic [ADDR_WIDTH-1:0] addr_r, sel_addr_s;
  logic [NUM_REQ-1:0]    gnt_s, gid_oh_s;
  logic                  any_s, in_range_s, done_s;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (req_arvalid),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gidx_s),
    .any     (any_s)
  );

  assign sel_addr_s = req_araddr[int'(gidx_s)*ADDR_WIDTH +: ADDR_WIDTH];
  assign in_range_s = {1'b0, sel_addr_s} < ADDR_LIMIT;
  assign gid_oh_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << gid_r;
  assign gid_next_s = (gid_r == IW'(NUM_REQ-1)) ? {IW{1'b0}} : gid_r + IW'(1);
  assign done_s     = ((state_r == S_DATA) && m_rvalid && m_rready) ||
                      ((state_r == S_ERR) && req_rready[gid_r]);

  // next-state and settle counter
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (any_s) state_nx_s = in_range_s ? S_ADDR : S_ERR;
        else       state_nx_s = S_IDLE;
      end
      S_ADDR: begin
        if (m_arready) begin
          state_nx_s = (R_SETTLE == 0) ? S_DATA : S_SETTLE;
          cnt_nx_s   = 3'd0;
        end else begin
          state_nx_s = S_ADDR;
        end
      end
      S_SETTLE: begin
        // only cycles with rvalid high count toward the settle window
        if (m_rvalid && (cnt_r + 3'd1 == SETTLE_LAST)) state_nx_s = S_DATA;
        else if (m_rvalid)                            cnt_nx_s   = cnt_r + 3'd1;
        else                                          state_nx_s = S_SETTLE;
      end
      S_DATA:  state_nx_s = done_s ? S_IDLE : S_DATA;
      S_ERR:   state_nx_s = done_s ? S_IDLE : S_ERR;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // state, grant latch and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 3'd0;
      ptr_r   <= '0;
      gid_r   <= '0;
      addr_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if ((state_r == S_IDLE) && any_s) begin
        gid_r  <= gidx_s;
        addr_r <= sel_addr_s;
      end else begin
        gid_r  <= gid_r;
        addr_r <= addr_r;
      end
      if (done_s) ptr_r <= gid_next_s;
      else        ptr_r <= ptr_r;
    end
  end

  // channel steering per state
  always_comb begin
    req_arready = '0;
    req_rvalid  = '0;
    req_rdata   = '0;
    req_rresp   = RESP_OKAY;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    case (state_r)
      S_IDLE:   req_arready = gnt_s;
      S_ADDR:   m_arvalid   = 1'b1;
      S_SETTLE: m_arvalid   = 1'b0;
      S_DATA: begin
        req_rvalid = gid_oh_s & {NUM_REQ{m_rvalid}};
        req_rdata  = m_rdata;
        req_rresp  = m_rresp;
        m_rready   = req_rready[gid_r];
      end
      S_ERR: begin
        req_rvalid = gid_oh_s;
        req_rresp  = RESP_SLVERR;
      end
      default: m_arvalid = 1'b0;
    endcase
  end

  assign m_araddr = addr_r;
  assign m_arprot = ARPROT_INSN;
  assign busy     = (state_r != S_IDLE);
  assign grant_id = gid_r;
endmodule

// File: tb/tb_axi4lite_imem_rd_arbiter.sv
// Directed + randomized bench for axi4lite_imem_rd_arbiter with a simple IMEM slave model.
module tb_axi4lite_imem_rd_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int N    = 2;
  localparam int IMEM = 1048576;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] req_araddr;
  logic [N-1:0]    req_arvalid, req_arready, req_rvalid, req_rready;
  logic [DW-1:0]   req_rdata;
  logic [1:0]      req_rresp;
  logic [AW-1:0]   m_araddr;
  logic [2:0]      m_arprot;
  logic            m_arvalid, m_arready, m_rvalid, m_rready, busy;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic [0:0]      grant_id;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  logic [31:0] mem [0:255];

  int          stall_req = 0;
  int          ar_wait;
  logic        rpend;
  logic [31:0] s_rdata;

  axi4lite_imem_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N),
                             .IMEM_BYTES(IMEM), .R_SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_araddr(req_araddr), .req_arvalid(req_arvalid),
    .req_arready(req_arready), .req_rdata(req_rdata), .req_rresp(req_rresp),
    .req_rvalid(req_rvalid), .req_rready(req_rready), .m_araddr(m_araddr),
    .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // IMEM slave: accepts after stall_req cycles of arvalid, returns data the next cycle
  assign m_arready = !rpend && (ar_wait >= stall_req);
  assign m_rvalid  = rpend;
  assign m_rdata   = s_rdata;
  assign m_rresp   = 2'b00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpend <= 1'b0; ar_wait <= 0; s_rdata <= 32'h0;
    end else begin
      if (m_arvalid && m_arready) begin
        rpend <= 1'b1; s_rdata <= mem[m_araddr[9:2]]; ar_wait <= 0;
      end else if (m_arvalid) begin
        ar_wait <= ar_wait + 1;
      end
      if (m_rvalid && m_rready) rpend <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0; v[i] = 1'b1;
    return v;
  endfunction

  // reference grant rule: first valid requester at or after the pointer, wrapping
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (a < IMEM) ? mem[w[7:0]] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [31:0] a);
    return (a < IMEM) ? 2'b00 : 2'b10;
  endfunction

  task automatic do_read(input int r, input logic [31:0] a, input int hold, input int exp_lat);
    int lat;
    logic [31:0] d;
    d = exp_data(a);
    req_araddr[r*AW +: AW] = a;
    req_arvalid[r] = 1'b1;
    req_rready[r]  = (hold == 0);
    #1;
    check("arready", req_arready, oh(rr_pick(req_arvalid, ptr_m)));
    tick;
    req_arvalid[r] = 1'b0;
    #1;
    check("m_arvalid_T1", m_arvalid, a < IMEM);
    if (a < IMEM) check("m_araddr", m_araddr, a);
    lat = 1;
    while (req_rvalid == '0 && lat < 30) begin tick; lat++; end
    check("latency", lat, exp_lat);
    check("rvalid", req_rvalid, oh(r));
    check("rdata", req_rdata, d);
    check("rresp", req_rresp, exp_rresp(a));
    check("grant_id", grant_id, r);
    for (int k = 0; k < hold; k++) begin
      check("hold_m_rready", m_rready, 1'b0);
      check("hold_rdata", req_rdata, d);
      tick;
    end
    req_rready[r] = 1'b1;
    #1;
    tick;
    check("idle_after", busy, 1'b0);
    ptr_m = (r + 1) % N;
  endtask

  initial begin
    int pend_r, done, cyc;
    logic [31:0] pend_d, na;
    logic [1:0]  pend_rs;
    int g_hist[$];

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[4] = 32'hDEADBEEF;
    rst_n = 1'b0; req_arvalid = '0; req_rready = '1; req_araddr = '0;
    tick; tick;
    check("rst_busy", busy, 1'b0);
    check("rst_arready", req_arready, 2'b00);
    check("rst_rvalid", req_rvalid, 2'b00);
    check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_m_araddr", m_araddr, 32'h0);
    check("rst_rdata", req_rdata, 32'h0);
    check("rst_grant_id", grant_id, 1'b0);
    rst_n = 1'b1;
    tick;

    do_read(0, 32'h10, 0, 3);
    check("arprot", m_arprot, 3'b100);
    do_read(1, 32'h0010_0000, 0, 1);
    do_read(1, 32'h20, 5, 3);

    // slave stalls arready for three cycles while another requester waits
    stall_req = 3;
    req_araddr[0 +: AW] = 32'h40; req_arvalid[0] = 1'b1; #1;
    check("stall_arready", req_arready, oh(rr_pick(req_arvalid, ptr_m)));
    tick;
    req_arvalid = 2'b10; req_araddr[AW +: AW] = 32'h44; #1;
    for (int k = 0; k < 3; k++) begin
      check("stall_m_arvalid", m_arvalid, 1'b1);
      check("stall_m_araddr", m_araddr, 32'h40);
      check("stall_req_arready", req_arready, 2'b00);
      tick;
    end
    req_arvalid = 2'b00; stall_req = 0; #1;
    cyc = 0;
    while (req_rvalid == '0 && cyc < 30) begin tick; cyc++; end
    check("stall_rdata", req_rdata, exp_data(32'h40));
    check("stall_rvalid", req_rvalid, 2'b01);
    tick;
    ptr_m = 1;

    // reset while waiting in the settle state
    req_araddr[0 +: AW] = 32'h18; req_arvalid[0] = 1'b1; #1;
    tick; req_arvalid[0] = 1'b0; #1;
    tick;
    check("settle_busy", busy, 1'b1);
    check("settle_rvalid", req_rvalid, 2'b00);
    rst_n = 1'b0; #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_m_arvalid", m_arvalid, 1'b0);
    check("mid_rst_m_rready", m_rready, 1'b0);
    check("mid_rst_rvalid", req_rvalid, 2'b00);
    check("mid_rst_rdata", req_rdata, 32'h0);
    check("mid_rst_m_araddr", m_araddr, 32'h0);
    ptr_m = 0;
    tick; rst_n = 1'b1; tick;
    do_read(1, 32'h8, 0, 3);

    // both requesters continuously valid, random addresses, some out of range
    for (int r = 0; r < N; r++)
      req_araddr[r*AW +: AW] = ($urandom_range(0, 3) == 0) ? IMEM + $urandom_range(0, 4096)
                                                             : ($urandom & 32'h000F_FFFC);
    req_arvalid = 2'b11; req_rready = 2'b11;
    pend_r = 0; pend_d = 32'h0; pend_rs = 2'b00; done = 0; cyc = 0;
    while (done < 8 && cyc < 400) begin
      #1;
      check("rvalid_onehot", $countones(req_rvalid) <= 1, 1'b1);
      if (req_rvalid != '0) begin
        check("rnd_rvalid", req_rvalid, oh(pend_r));
        check("rnd_rdata", req_rdata, pend_d);
        check("rnd_rresp", req_rresp, pend_rs);
        done++;
        ptr_m = (pend_r + 1) % N;
      end
      if (req_arready != '0) begin
        pend_r = rr_pick(req_arvalid, ptr_m);
        check("rnd_arready", req_arready, oh(pend_r));
        na      = req_araddr[pend_r*AW +: AW];
        pend_d  = exp_data(na);
        pend_rs = exp_rresp(na);
        g_hist.push_back(pend_r);
        tick;
        req_araddr[pend_r*AW +: AW] = ($urandom_range(0, 3) == 0) ? IMEM + $urandom_range(0, 4096)
                                                                   : ($urandom & 32'h000F_FFFC);
      end else begin
        tick;
      end
      cyc++;
    end
    check("rnd_completed", done, 8);
    for (int k = 0; k < 6; k++)
      check("alternate", (k < g_hist.size()) ? g_hist[k] : -1, k % 2);
    req_arvalid = '0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
